// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive sequencer driving sampler, deserializer and start/parity/stop checkers
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stop_err,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               data_valid,
  output logic               frame_err
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t             state_q, state_d;
  logic [PRESC_W-1:0] p_q, p_d, edge_q, edge_d, p_sel, half, at_chk, at_lat;
  logic [3:0]         bit_q, bit_d;
  logic               perr_q, perr_d, serr_q, serr_d;
  logic               wrap, chk, lat, err_any;
  assign p_sel   = (prescale == PRESC_W'(16) || prescale == PRESC_W'(32)) ? prescale : PRESC_W'(8);
  assign half    = p_q >> 1;
  assign at_chk  = half + PRESC_W'(2);
  assign at_lat  = half + PRESC_W'(3);
  assign wrap    = edge_q == p_q - PRESC_W'(1);
  assign chk     = edge_q == at_chk;
  assign lat     = edge_q == at_lat;
  // At P=8 the stop result arrives in the final cycle, so it must bypass the latch
  assign err_any = perr_q | serr_q | (lat & stop_err);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= PRESC_W'(8);
      edge_q  <= '0;
      bit_q   <= '0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    edge_d  = wrap ? '0 : edge_q + PRESC_W'(1);
    bit_d   = bit_q;
    perr_d  = perr_q;
    serr_d  = serr_q;
    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        serr_d = 1'b0;
        if (!rx_in) begin
          state_d = START;
          p_d     = p_sel;
        end
      end
      START: begin
        if (lat && strt_glitch) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (wrap && bit_q == 4'(DATA_WIDTH - 1)) begin
          bit_d   = '0;
          state_d = par_en ? PARITY : STOP;
        end else if (wrap) bit_d = bit_q + 4'd1;
      end
      PARITY: begin
        if (lat && par_err) perr_d = 1'b1;
        if (wrap) state_d = STOP;
      end
      STOP: begin
        if (lat && stop_err) serr_d = 1'b1;
        if (wrap) begin
          perr_d  = 1'b0;
          serr_d  = 1'b0;
          state_d = rx_in ? IDLE : START;
          p_d     = rx_in ? p_q : p_sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign dat_samp_en = state_q != IDLE;
  assign deser_en    = state_q == DATA   && chk;
  assign strt_chk_en = state_q == START  && chk;
  assign par_chk_en  = state_q == PARITY && chk;
  assign stp_chk_en  = state_q == STOP   && chk;
  assign data_valid  = state_q == STOP && wrap && !err_any;
  assign frame_err   = state_q == STOP && wrap && err_any;
  assign edge_cnt    = edge_q;
  assign bit_cnt     = bit_q;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed scenario bench for the UART RX sequencer
module tb_uart_rx_fsm;
  logic       clk = 0, rst_n = 0, rx_in = 1, par_en = 0;
  logic       strt_glitch = 0, par_err = 0, stop_err = 0;
  logic [5:0] prescale = 6'd8;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [10:0] fr = '1;
  int checks = 0, errors = 0;
  int cyc, cur_p = 8, flen, dexp;
  int n_deser, bad_edge, n_dv, n_fe, dv_cyc, fe_cyc, n_strt, n_par, n_stp, overlap;
  bit b2b, inj_g, inj_p, inj_s, pv_t, pv_p, pv_s;

  uart_rx_fsm dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stop_err(stop_err),
    .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt), .data_valid(data_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task clear();
    cyc = 0; n_deser = 0; bad_edge = 0; n_dv = 0; n_fe = 0; dv_cyc = 0; fe_cyc = 0;
    n_strt = 0; n_par = 0; n_stp = 0; overlap = 0;
  endtask

  task cycle();
    int idx;
    @(negedge clk);
    strt_glitch = pv_t & inj_g;
    par_err     = pv_p & inj_p;
    stop_err    = pv_s & inj_s;
    idx = cyc / cur_p;
    rx_in = (b2b && cyc + 1 == flen) ? 1'b0 : (idx < 11 ? fr[idx] : 1'b1);
    #1;
    cyc++;
    if (deser_en) begin n_deser++; if (int'(edge_cnt) != dexp) bad_edge++; end
    if (data_valid) begin n_dv++; dv_cyc = cyc; end
    if (frame_err) begin n_fe++; fe_cyc = cyc; end
    if (strt_chk_en) n_strt++;
    if (par_chk_en) n_par++;
    if (stp_chk_en) n_stp++;
    if (int'(deser_en) + int'(strt_chk_en) + int'(par_chk_en) + int'(stp_chk_en) > 1 || (data_valid && frame_err)) overlap++;
    pv_t = strt_chk_en; pv_p = par_chk_en; pv_s = stp_chk_en;
  endtask

  task run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task start_frame(input logic [5:0] ps, input int p, input logic [7:0] d, input bit par);
    @(negedge clk);
    prescale = ps;
    par_en = par;
    fr = {2'b11, d, 1'b0};
    if (par) fr[9] = ^d;
    cur_p = p;
    dexp = p / 2 + 2;
    flen = (10 + int'(par)) * p;
    rx_in = 1'b0;
    clear();
  endtask

  task test_reset();
    #12;
    checks++;
    if ({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err, edge_cnt, bit_cnt} !== 17'd0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0", {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err, edge_cnt, bit_cnt});
    end
    @(negedge clk); rst_n = 1;
    clear(); run(3);
    checks++; if (dat_samp_en !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %b exp 0", dat_samp_en); end
  endtask

  task test_8n1();
    start_frame(6'd8, 8, 8'hA5, 0);
    run(90);
    checks++; if (n_deser !== 8) begin errors++; $display("FAIL 8n1_deser_count got %0d exp 8", n_deser); end
    checks++; if (bad_edge !== 0) begin errors++; $display("FAIL 8n1_deser_edge got %0d bad exp 0", bad_edge); end
    checks++; if (n_dv !== 1 || dv_cyc !== 80) begin errors++; $display("FAIL 8n1_data_valid got %0d at %0d exp 1 at 80", n_dv, dv_cyc); end
    checks++; if (n_fe !== 0) begin errors++; $display("FAIL 8n1_frame_err got %0d exp 0", n_fe); end
    checks++; if (n_strt !== 1 || n_stp !== 1 || n_par !== 0) begin errors++; $display("FAIL 8n1_chk_en got %0d/%0d/%0d exp 1/0/1", n_strt, n_par, n_stp); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL 8n1_overlap got %0d exp 0", overlap); end
    checks++; if (dat_samp_en !== 1'b0) begin errors++; $display("FAIL 8n1_back_idle got %b exp 0", dat_samp_en); end
  endtask

  task test_parity_err();
    inj_p = 1;
    start_frame(6'd16, 16, 8'h3C, 1);
    run(190);
    inj_p = 0;
    checks++; if (n_fe !== 1 || fe_cyc !== 176) begin errors++; $display("FAIL par_frame_err got %0d at %0d exp 1 at 176", n_fe, fe_cyc); end
    checks++; if (n_dv !== 0) begin errors++; $display("FAIL par_data_valid got %0d exp 0", n_dv); end
    checks++; if (n_par !== 1 || n_deser !== 8 || bad_edge !== 0) begin errors++; $display("FAIL par_enables got par %0d deser %0d bad %0d exp 1 8 0", n_par, n_deser, bad_edge); end
  endtask

  task test_glitch();
    inj_g = 1;
    start_frame(6'd8, 8, 8'hFF, 0);
    run(8);
    checks++; if (dat_samp_en !== 1'b1 || edge_cnt !== 6'd7) begin errors++; $display("FAIL glitch_pre got samp %b edge %0d exp 1 7", dat_samp_en, edge_cnt); end
    run(1);
    checks++; if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) begin errors++; $display("FAIL glitch_idle got samp %b edge %0d exp 0 0", dat_samp_en, edge_cnt); end
    run(20);
    inj_g = 0;
    checks++; if (n_deser !== 0 || n_dv !== 0 || n_fe !== 0) begin errors++; $display("FAIL glitch_pulses got %0d/%0d/%0d exp 0/0/0", n_deser, n_dv, n_fe); end
  endtask

  task test_stop_err();
    int ps [2] = '{32, 8};
    foreach (ps[k]) begin
      inj_s = 1;
      start_frame(6'(ps[k]), ps[k], 8'h0F, 0);
      run(ps[k] * 10 + 5);
      inj_s = 0;
      checks++; if (n_fe !== 1 || fe_cyc !== ps[k] * 10) begin errors++; $display("FAIL stop_err_p%0d got %0d at %0d exp 1 at %0d", ps[k], n_fe, fe_cyc, ps[k] * 10); end
      checks++; if (n_dv !== 0) begin errors++; $display("FAIL stop_dv_p%0d got %0d exp 0", ps[k], n_dv); end
    end
  endtask

  task test_back_to_back();
    b2b = 1;
    start_frame(6'd8, 8, 8'h5A, 0);
    run(40);
    prescale = 6'd16;
    run(40);
    b2b = 0;
    checks++; if (n_dv !== 1 || dv_cyc !== 80) begin errors++; $display("FAIL b2b_first_dv got %0d at %0d exp 1 at 80", n_dv, dv_cyc); end
    checks++; if (n_deser !== 8 || bad_edge !== 0) begin errors++; $display("FAIL b2b_first_deser got %0d bad %0d exp 8 0", n_deser, bad_edge); end
    clear(); cur_p = 16; dexp = 10; flen = 160; fr = {2'b11, 8'h81, 1'b0};
    run(1);
    checks++; if (dat_samp_en !== 1'b1 || edge_cnt !== 6'd0) begin errors++; $display("FAIL b2b_no_idle got samp %b edge %0d exp 1 0", dat_samp_en, edge_cnt); end
    run(169);
    checks++; if (n_dv !== 1 || dv_cyc !== 160) begin errors++; $display("FAIL b2b_second_dv got %0d at %0d exp 1 at 160", n_dv, dv_cyc); end
    checks++; if (n_deser !== 8 || bad_edge !== 0) begin errors++; $display("FAIL b2b_second_deser got %0d bad %0d exp 8 0", n_deser, bad_edge); end
  endtask

  task test_reset_midframe();
    bit found = 0;
    start_frame(6'd8, 8, 8'h00, 0);
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (dat_samp_en && bit_cnt == 4'd3) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_reach_bit3 got 0 exp 1"); end
    #2 rst_n = 0; fr = '1;
    #1;
    checks++;
    if ({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err, edge_cnt, bit_cnt} !== 17'd0) begin
      errors++; $display("FAIL rst_async got %b exp 0", {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err, edge_cnt, bit_cnt});
    end
    clear(); run(3);
    rst_n = 1;
    run(5);
    checks++; if (n_dv !== 0 || n_fe !== 0 || dat_samp_en !== 1'b0) begin errors++; $display("FAIL rst_aborted got dv %0d fe %0d samp %b exp 0 0 0", n_dv, n_fe, dat_samp_en); end
    start_frame(6'd5, 8, 8'h96, 0);
    run(85);
    checks++; if (n_deser !== 8 || bad_edge !== 0) begin errors++; $display("FAIL rst_illegal_p got deser %0d bad %0d exp 8 0", n_deser, bad_edge); end
    checks++; if (n_dv !== 1 || dv_cyc !== 80) begin errors++; $display("FAIL rst_illegal_dv got %0d at %0d exp 1 at 80", n_dv, dv_cyc); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_err();
    test_glitch();
    test_stop_err();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side sequencer for the UART RX path. It detects the start edge on the serial line, runs the per-bit oversampling edge counter and the bit counter, and issues one-cycle enables to the data sampler, the deserializer, and the start, parity and stop checkers. It latches the checkers' error results and pulses `data_valid` when a frame completes cleanly. It sits between the serial input pin and the `StopCheck`/parity/start-check/deserializer blocks.

## Interface
- `DATA_WIDTH`, 8, number of data bits per frame (LSB first).
- `PRESC_W`, 6, width of the `prescale` input and of `edge_cnt`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_in` input 1: serial line; idle high.
- `par_en` input 1: 1 = frame carries a parity bit.
- `prescale` input PRESC_W: oversampling ratio.
  - Legal values: 8, 16, 32. Any other value is treated as 8.
  - Captured at frame start.
- `strt_glitch` input 1: start checker result; valid the cycle after `strt_chk_en`.
- `par_err` input 1: parity checker result; valid the cycle after `par_chk_en`.
- `stop_err` input 1: stop checker result; valid the cycle after `stp_chk_en`.
- `dat_samp_en` output 1: enables the 3-point majority sampler.
- `deser_en` output 1: one-cycle shift pulse to the deserializer.
- `strt_chk_en` output 1: one-cycle pulse.
- `par_chk_en` output 1: one-cycle pulse.
- `stp_chk_en` output 1: one-cycle pulse.
- `edge_cnt` output PRESC_W: oversample position within the current bit, 0..P-1.
- `bit_cnt` output 4: data bit index, 0..DATA_WIDTH-1.
- `data_valid` output 1: one-cycle pulse; the frame is good.
- `frame_err` output 1: one-cycle pulse at the end of a frame with a parity or stop error.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- P is the captured prescale. M = P/2. The sampler takes samples at edge counts M-1, M and M+1.
- **IDLE**
  - Counters are held at 0. The error latches are cleared.
  - When `rx_in` is 0: capture P, enter START with `edge_cnt`=0.
- **Edge counter**
  - Increments every cycle outside IDLE.
  - Wraps from P-1 to 0. The wrap marks the bit boundary.
- **START**
  - `strt_chk_en` pulses at `edge_cnt`=M+2.
  - At `edge_cnt`=M+3, if `strt_glitch`=1: go to IDLE immediately. No other outputs pulse.
  - At the wrap: go to DATA with `bit_cnt`=0.
- **DATA**
  - `deser_en` pulses at `edge_cnt`=M+2.
  - At the wrap, `bit_cnt` increments.
  - At the wrap with `bit_cnt`=DATA_WIDTH-1: go to PARITY if `par_en`, else to STOP. `bit_cnt` returns to 0.
- **PARITY**
  - `par_chk_en` pulses at `edge_cnt`=M+2.
  - `par_err` is latched into a sticky flag at M+3.
  - At the wrap: go to STOP.
- **STOP**
  - `stp_chk_en` pulses at `edge_cnt`=M+2.
  - `stop_err` is latched at M+3. This is required because the stop checker clears its error output when its enable drops.
  - At `edge_cnt`=P-1, exactly one of these pulses:
    - `data_valid`, if neither error latch is set;
    - `frame_err`, otherwise.
  - Next state:
    - if `rx_in`=0 on that same cycle: START with a new P captured (back-to-back frame);
    - otherwise: IDLE.
- `dat_samp_en` is 1 in every state except IDLE.
- `par_en` is sampled at the DATA→next transition only.
- Changes to `prescale` or `par_en` mid-frame do not affect the frame in progress.

## Timing
- Reset values:
  - state is IDLE;
  - `edge_cnt`, `bit_cnt`, all enables, `data_valid` and `frame_err` are 0;
  - the error latches are 0.
- Reset asserted mid-frame forces all of the above asynchronously. No `data_valid` or `frame_err` is produced for the aborted frame.
- All outputs are registered or decoded directly from registered state and counters. There are no combinational paths from `rx_in`.
- Start detection: IDLE→START takes effect on the first clock edge at which `rx_in`=0. `edge_cnt` is 0 in the following cycle.
- Frame length outside IDLE: (2 + DATA_WIDTH + `par_en`)·P cycles.
  - For 8N1 at P=8: 80 cycles.
  - `data_valid` is asserted in the last of those cycles.
- Enables never overlap. At most one checker enable is high in any cycle.

## Test plan
- 8N1 frame 0xA5, P=8, `par_en`=0, all checker errors 0:
  - `deser_en` pulses 8 times at `edge_cnt`=6;
  - `data_valid` pulses once, 80 cycles after start detection;
  - `frame_err` stays 0.
- 8E1 frame, P=16, `par_err` driven to 1 for one cycle after `par_chk_en`:
  - `frame_err` pulses at the end of the stop bit;
  - `data_valid` stays 0;
  - total frame length is 176 cycles.
- Start glitch, P=8, `strt_glitch`=1 at `edge_cnt`=7:
  - state returns to IDLE on the next cycle;
  - no `deser_en`, `data_valid` or `frame_err` pulse.
- `stop_err`=1 for the single cycle after `stp_chk_en`, P=32: the latched value still produces `frame_err`.
- Back-to-back frames with `rx_in` low at stop `edge_cnt`=P-1:
  - `data_valid` pulses;
  - the FSM enters START directly with no IDLE cycle;
  - the second frame completes with `data_valid`.
- `rst_n` pulled low at DATA `bit_cnt`=3; `prescale`=5 on the next frame:
  - on reset, all outputs are immediately 0;
  - the next frame runs with P=8, i.e. `deser_en` at `edge_cnt`=6.
